// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_RES_W  = 8;
  localparam int unsigned DEF_OP_W   = 3;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Op-select encoding understood by the shared ALU
  localparam logic [DEF_OP_W-1:0] OP_RIPPLE = 3'd0;
  localparam logic [DEF_OP_W-1:0] OP_ADD    = 3'd1;
  localparam logic [DEF_OP_W-1:0] OP_ORXOR  = 3'd2;
  localparam logic [DEF_OP_W-1:0] OP_ANYONE = 3'd3;
  localparam logic [DEF_OP_W-1:0] OP_ALLONE = 3'd4;
  localparam logic [DEF_OP_W-1:0] OP_SHL    = 3'd5;
  localparam logic [DEF_OP_W-1:0] OP_SHR    = 3'd6;
  localparam logic [DEF_OP_W-1:0] OP_MUL    = 3'd7;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-requester round-robin grant; the requester that did not win last time wins a tie.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       gnt_valid_c,
  output logic       gnt_id_c
);

  always_comb begin
    gnt_valid_c = |valid;
    gnt_id_c    = 1'b0;
    case (valid)
      2'b01:   gnt_id_c = 1'b0;
      2'b10:   gnt_id_c = 1'b1;
      2'b11:   gnt_id_c = ~last_grant;
      default: gnt_id_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight.
// Optional per-requester accumulators feeding operand B: define ALU_ARB_ACC_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned RES_W   = DEF_RES_W,
  parameter int unsigned OP_W    = DEF_OP_W,
  parameter int unsigned ALU_LAT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_use_acc,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_use_acc,
  output logic              rsp1_valid,
  output logic [RES_W-1:0]  rsp_result,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_key,
  input  logic [RES_W-1:0]  alu_out,
  output logic              busy,
  output logic              grant_id
);

  state_t            state;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic [OP_W-1:0]   opk;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              gnt_valid_c;
  logic              gnt_id_c;
  logic              xfer_c;
  logic              capture_c;
  logic [DATA_W-1:0] b_sel_c;

  rr_arb2 u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_grant  (last_grant),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  // Ready is only offered in IDLE and never while reset is held
  assign req0_ready = !reset && (state == S_IDLE) && gnt_valid_c && !gnt_id_c;
  assign req1_ready = !reset && (state == S_IDLE) && gnt_valid_c &&  gnt_id_c;
  assign xfer_c     = req0_ready || req1_ready;
  assign capture_c  = (state == S_EXEC) && (cnt == '0);

  assign alu_a   = opa;
  assign alu_b   = opb;
  assign alu_key = opk;

`ifdef ALU_ARB_ACC_EN
  logic [RES_W-1:0] acc0;
  logic [RES_W-1:0] acc1;
  logic             unused_acc_hi;

  always_ff @(posedge clock) begin
    if (reset) begin
      acc0 <= '0;
      acc1 <= '0;
    end else if (capture_c) begin
      if (grant_id) acc1 <= alu_out;
      else          acc0 <= alu_out;
    end
  end

  always_comb begin
    b_sel_c = gnt_id_c ? req1_b : req0_b;
    if (gnt_id_c ? req1_use_acc : req0_use_acc)
      b_sel_c = gnt_id_c ? acc1[DATA_W-1:0] : acc0[DATA_W-1:0];
  end

  assign unused_acc_hi = &{1'b0, acc0[RES_W-1:DATA_W], acc1[RES_W-1:DATA_W]};
`else
  logic unused_use_acc;

  always_comb begin
    b_sel_c = gnt_id_c ? req1_b : req0_b;
  end

  assign unused_use_acc = &{1'b0, req0_use_acc, req1_use_acc};
`endif

  // Control FSM and operand/result datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      opa        <= '0;
      opb        <= '0;
      opk        <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer_c) begin
            opa        <= gnt_id_c ? req1_a  : req0_a;
            opb        <= b_sel_c;
            opk        <= gnt_id_c ? req1_op : req0_op;
            grant_id   <= gnt_id_c;
            last_grant <= gnt_id_c;
            cnt        <= CNT_W'(ALU_LAT);
            busy       <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_out;
            rsp0_valid <= !grant_id;
            rsp1_valid <= grant_id;
            state      <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: instance A has ALU_LAT=0, instance B has ALU_LAT=3; request inputs are shared.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic       clock = 1'b0;
  logic       reset_a, reset_b;
  logic       req0_valid, req1_valid, req0_use_acc, req1_use_acc;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;

  logic       a_req0_ready, a_req1_ready, a_rsp0_valid, a_rsp1_valid, a_busy, a_grant_id;
  logic [7:0] a_rsp_result, a_alu_out;
  logic [3:0] a_alu_a, a_alu_b;
  logic [2:0] a_alu_key;
  logic       b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_busy, b_grant_id;
  logic [7:0] b_rsp_result, b_alu_out;
  logic [3:0] b_alu_a, b_alu_b;
  logic [2:0] b_alu_key;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Behavioural stand-in for the shared ALU
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] k);
    case (k)
      3'd0, 3'd1: return 8'(a) + 8'(b);
      3'd2:       return {a | b, a ^ b};
      3'd3:       return 8'(|{a, b});
      3'd4:       return 8'(&{a, b});
      3'd5:       return 8'(b) << a;
      3'd6:       return 8'(b) >> a;
      default:    return 8'(a) * 8'(b);
    endcase
  endfunction

  assign a_alu_out = alu_f(a_alu_a, a_alu_b, a_alu_key);
  assign b_alu_out = alu_f(b_alu_a, b_alu_b, b_alu_key);

  alu_arbiter #(.ALU_LAT(0)) u_dut_a (
    .clock(clock), .reset(reset_a),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_use_acc(req0_use_acc), .rsp0_valid(a_rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_use_acc(req1_use_acc), .rsp1_valid(a_rsp1_valid),
    .rsp_result(a_rsp_result), .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_key(a_alu_key),
    .alu_out(a_alu_out), .busy(a_busy), .grant_id(a_grant_id)
  );

  alu_arbiter #(.ALU_LAT(3)) u_dut_b (
    .clock(clock), .reset(reset_b),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_use_acc(req0_use_acc), .rsp0_valid(b_rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_use_acc(req1_use_acc), .rsp1_valid(b_rsp1_valid),
    .rsp_result(b_rsp_result), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_key(b_alu_key),
    .alu_out(b_alu_out), .busy(b_busy), .grant_id(b_grant_id)
  );

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (a_req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %0b exp 0", a_req0_ready); end
    checks++; if (a_req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %0b exp 0", a_req1_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", a_busy); end
    checks++; if (a_rsp_result !== 8'h00) begin errors++; $display("FAIL rst_result got %0h exp 0", a_rsp_result); end
    checks++; if (a_grant_id !== 1'b0) begin errors++; $display("FAIL rst_grant got %0b exp 0", a_grant_id); end
    checks++; if ({a_alu_a, a_alu_b, a_alu_key} !== 11'h0) begin errors++; $display("FAIL rst_alu got %0h exp 0", {a_alu_a, a_alu_b, a_alu_key}); end
    checks++; if ({a_rsp0_valid, a_rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rst_rsp got %0b exp 00", {a_rsp0_valid, a_rsp1_valid}); end
    checks++; if ({b_busy, b_req0_ready, b_req1_ready} !== 3'b000) begin errors++; $display("FAIL rst_b got %0b exp 000", {b_busy, b_req0_ready, b_req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_a = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_req0_ripple();
    req0_a = 4'd5; req0_b = 4'd3; req0_op = OP_RIPPLE; req0_valid = 1'b1;
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b01) begin errors++; $display("FAIL r0_ready got %0b exp 01", {a_req1_ready, a_req0_ready}); end
    @(negedge clock); #1;
    checks++; if ({a_alu_a, a_alu_b, a_alu_key} !== {4'd5, 4'd3, 3'd0}) begin errors++; $display("FAIL r0_alu_in got %0h exp %0h", {a_alu_a, a_alu_b, a_alu_key}, {4'd5, 4'd3, 3'd0}); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL r0_busy got %0b exp 1", a_busy); end
    checks++; if (a_req0_ready !== 1'b0) begin errors++; $display("FAIL r0_ready_exec got %0b exp 0", a_req0_ready); end
    checks++; if (a_rsp0_valid !== 1'b0) begin errors++; $display("FAIL r0_rsp_early got %0b exp 0", a_rsp0_valid); end
    req0_valid = 1'b0;
    @(negedge clock); #1;
    checks++; if ({a_rsp1_valid, a_rsp0_valid} !== 2'b01) begin errors++; $display("FAIL r0_rsp got %0b exp 01", {a_rsp1_valid, a_rsp0_valid}); end
    checks++; if (a_rsp_result !== 8'h08) begin errors++; $display("FAIL r0_result got %0h exp 08", a_rsp_result); end
    @(negedge clock); #1;
    checks++; if ({a_rsp1_valid, a_rsp0_valid, a_busy} !== 3'b000) begin errors++; $display("FAIL r0_after got %0b exp 000", {a_rsp1_valid, a_rsp0_valid, a_busy}); end
    checks++; if (a_rsp_result !== 8'h08) begin errors++; $display("FAIL r0_hold got %0h exp 08", a_rsp_result); end
  endtask

  task automatic test_req1_mul();
    req1_a = 4'd15; req1_b = 4'd15; req1_op = OP_MUL; req1_valid = 1'b1;
    #1;
    checks++; if ({a_req1_ready, a_req0_ready} !== 2'b10) begin errors++; $display("FAIL r1_ready got %0b exp 10", {a_req1_ready, a_req0_ready}); end
    @(negedge clock); #1;
    req1_valid = 1'b0;
    checks++; if (a_grant_id !== 1'b1) begin errors++; $display("FAIL r1_grant got %0b exp 1", a_grant_id); end
    checks++; if (a_alu_key !== 3'd7) begin errors++; $display("FAIL r1_key got %0d exp 7", a_alu_key); end
    @(negedge clock); #1;
    checks++; if ({a_rsp1_valid, a_rsp0_valid} !== 2'b10) begin errors++; $display("FAIL r1_rsp got %0b exp 10", {a_rsp1_valid, a_rsp0_valid}); end
    checks++; if (a_rsp_result !== 8'hE1) begin errors++; $display("FAIL r1_result got %0h exp e1", a_rsp_result); end
    @(negedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic       g;
    logic [7:0] exp;
    req0_op = OP_ADD; req1_op = OP_ADD; req0_b = 4'd2; req1_b = 4'd5;
    for (int i = 0; i < 6; i++) begin
      req0_a = 4'(i); req1_a = 4'(i + 8);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      g   = 1'(i % 2);
      exp = g ? 8'(i + 8 + 5) : 8'(i + 2);
      checks++; if ({a_req1_ready, a_req0_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_ready[%0d] got %0b exp %0b", i, {a_req1_ready, a_req0_ready}, g ? 2'b10 : 2'b01); end
      @(negedge clock); #1;
      checks++; if (a_grant_id !== g) begin errors++; $display("FAIL b2b_grant[%0d] got %0b exp %0b", i, a_grant_id, g); end
      checks++; if ({a_req1_ready, a_req0_ready} !== 2'b00) begin errors++; $display("FAIL b2b_ready_exec[%0d] got %0b exp 00", i, {a_req1_ready, a_req0_ready}); end
      @(negedge clock); #1;
      checks++; if ({a_rsp1_valid, a_rsp0_valid} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_rsp[%0d] got %0b exp %0b", i, {a_rsp1_valid, a_rsp0_valid}, g ? 2'b10 : 2'b01); end
      checks++; if (a_rsp_result !== exp) begin errors++; $display("FAIL b2b_result[%0d] got %0h exp %0h", i, a_rsp_result, exp); end
      @(negedge clock); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_drop_in_exec();
    req0_a = 4'd3; req0_b = 4'd4; req0_op = OP_ADD; req0_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b1) begin errors++; $display("FAIL drop_ready got %0b exp 1", a_req0_ready); end
    @(negedge clock); #1;
    req0_valid = 1'b0;
    @(negedge clock); #1;
    req0_a = 4'd6; req0_b = 4'd6; req0_valid = 1'b1;
    #1;
    checks++; if (a_req0_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_resp got %0b exp 0", a_req0_ready); end
    checks++; if (a_rsp0_valid !== 1'b1 || a_rsp_result !== 8'h07) begin errors++; $display("FAIL drop_first got v=%0b r=%0h exp v=1 r=07", a_rsp0_valid, a_rsp_result); end
    @(negedge clock); #1;
    checks++; if (a_req0_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL drop_idle got rdy=%0b busy=%0b exp 1 0", a_req0_ready, a_busy); end
    @(negedge clock); #1;
    req0_valid = 1'b0;
    checks++; if (a_alu_a !== 4'd6) begin errors++; $display("FAIL drop_opa got %0d exp 6", a_alu_a); end
    @(negedge clock); #1;
    checks++; if (a_rsp0_valid !== 1'b1 || a_rsp_result !== 8'h0C) begin errors++; $display("FAIL drop_second got v=%0b r=%0h exp v=1 r=0c", a_rsp0_valid, a_rsp_result); end
    @(negedge clock); #1;
  endtask

  task automatic test_latency();
    reset_a = 1'b1; reset_b = 1'b0;
    @(negedge clock); #1;
    req1_a = 4'd2; req1_b = 4'd3; req1_op = OP_SHL; req1_valid = 1'b1;
    #1;
    checks++; if ({b_req1_ready, b_req0_ready} !== 2'b10) begin errors++; $display("FAIL lat_ready got %0b exp 10", {b_req1_ready, b_req0_ready}); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock); #1;
      req1_valid = 1'b0;
      checks++; if (b_rsp1_valid !== (k == 5)) begin errors++; $display("FAIL lat_rsp[T+%0d] got %0b exp %0b", k, b_rsp1_valid, k == 5); end
      checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL lat_busy[T+%0d] got %0b exp 1", k, b_busy); end
    end
    checks++; if (b_rsp_result !== 8'h0C) begin errors++; $display("FAIL lat_result got %0h exp 0c", b_rsp_result); end
    @(negedge clock); #1;
    checks++; if (b_busy !== 1'b0 || b_rsp1_valid !== 1'b0) begin errors++; $display("FAIL lat_idle got busy=%0b rsp=%0b exp 0 0", b_busy, b_rsp1_valid); end
  endtask

  task automatic test_reset_in_exec();
    req0_a = 4'd7; req0_b = 4'd7; req0_op = OP_ADD; req0_valid = 1'b1;
    #1;
    checks++; if (b_req0_ready !== 1'b1) begin errors++; $display("FAIL rexec_ready got %0b exp 1", b_req0_ready); end
    @(negedge clock); #1;
    req0_valid = 1'b0;
    reset_b = 1'b1;
    @(negedge clock); #1;
    reset_b = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rexec_busy got %0b exp 0", b_busy); end
    checks++; if (b_rsp_result !== 8'h00) begin errors++; $display("FAIL rexec_result got %0h exp 0", b_rsp_result); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock); #1;
      checks++; if ({b_rsp1_valid, b_rsp0_valid, b_busy} !== 3'b000) begin errors++; $display("FAIL rexec_quiet[%0d] got %0b exp 000", k, {b_rsp1_valid, b_rsp0_valid, b_busy}); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({b_req1_ready, b_req0_ready} !== 2'b01) begin errors++; $display("FAIL rexec_contend got %0b exp 01", {b_req1_ready, b_req0_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_use_acc();
`ifdef ALU_ARB_ACC_EN
    logic       sel [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] va  [3] = '{4'd5, 4'd1, 4'd2};
    logic [3:0] vb  [3] = '{4'd3, 4'd0, 4'd9};
    logic       vu  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ve  [3] = '{8'h08, 8'h09, 8'h02};
`else
    logic       sel [1] = '{1'b0};
    logic [3:0] va  [1] = '{4'd1};
    logic [3:0] vb  [1] = '{4'd2};
    logic       vu  [1] = '{1'b1};
    logic [7:0] ve  [1] = '{8'h03};
`endif
    for (int i = 0; i < $size(sel); i++) begin
      if (sel[i]) begin
        req1_a = va[i]; req1_b = vb[i]; req1_op = OP_ADD; req1_use_acc = vu[i]; req1_valid = 1'b1;
      end else begin
        req0_a = va[i]; req0_b = vb[i]; req0_op = OP_ADD; req0_use_acc = vu[i]; req0_valid = 1'b1;
      end
      #1;
      checks++; if ({b_req1_ready, b_req0_ready} !== (sel[i] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL acc_ready[%0d] got %0b", i, {b_req1_ready, b_req0_ready}); end
      @(negedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_use_acc = 1'b0; req1_use_acc = 1'b0;
      repeat (4) @(negedge clock);
      #1;
      checks++; if ({b_rsp1_valid, b_rsp0_valid} !== (sel[i] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL acc_rsp[%0d] got %0b", i, {b_rsp1_valid, b_rsp0_valid}); end
      checks++; if (b_rsp_result !== ve[i]) begin errors++; $display("FAIL acc_result[%0d] got %0h exp %0h", i, b_rsp_result, ve[i]); end
      @(negedge clock); #1;
    end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_use_acc = 1'b0; req1_use_acc = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
    test_reset();
    test_req0_ripple();
    test_req1_mul();
    test_back_to_back();
    test_drop_in_exec();
    test_latency();
    test_reset_in_exec();
    test_use_acc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational 8-op ALU between two requesters. Each requester has a valid/ready operand handshake and a response pulse.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU operand and op-select inputs, waits a configurable settle/latency count, then captures the ALU result in a register.
- Returns the captured result to the requester that issued the operation.
- Sits between front-end sources (switch/key capture, sequencing logic) and the shared ALU instance.

Parameters:
DATA_W, 4, operand width (A, B).
RES_W, 8, result width.
OP_W, 3, op-select width; op encoding is the ALU's: 0 ripple add, 1 add, 2 {or,xor}, 3 reduce-or, 4 reduce-and, 5 B<<A, 6 B>>A, 7 A*B.
ALU_LAT, 0, extra wait cycles in EXEC before capture; legal range 0..15.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a  in  DATA_W  operand A
req0_b  in  DATA_W  operand B
req0_op  in  OP_W  ALU op select
req0_use_acc  in  1  take B from accumulator 0 (effective only with ALU_ARB_ACC_EN)
rsp0_valid  out  1  one-cycle result pulse for requester 0
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_use_acc, rsp1_valid  as above, for requester 1
rsp_result  out  RES_W  last captured result, shared by both requesters
alu_a  out  DATA_W  to ALU A
alu_b  out  DATA_W  to ALU B
alu_key  out  OP_W  to ALU op select
alu_out  in  RES_W  from ALU (combinational)
busy  out  1  high when state != IDLE
grant_id  out  1  requester owning the current or last operation

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - Arbitration is round-robin, using last_grant.
  - If only one reqN_valid is high, that requester wins.
  - If both are high, the requester != last_grant wins.
  - The winner's reqN_ready is driven high combinationally in the same cycle. The loser's ready and both readies with no valid stay low.
  - On transfer, latch a/b/op into the operand registers, set grant_id and last_grant to the winner, load wait counter = ALU_LAT, and go to EXEC.
- EXEC
  - alu_a/alu_b/alu_key are driven continuously from the operand registers, which hold their last values in every state.
  - If counter == 0: capture alu_out into rsp_result and go to RESP.
  - Otherwise decrement the counter.
- RESP
  - rsp<grant_id>_valid is high for exactly one cycle; the other rsp stays low.
  - Next state is IDLE.
  - There is no response backpressure.
- Latency: transfer at cycle T gives rsp_valid at T+2+ALU_LAT. Throughput is one operation per 3+ALU_LAT cycles.
- Both reqN_ready are low outside IDLE. Valid may drop or change freely; only the transfer cycle's inputs matter.
- rsp_result holds until the next capture.
- Reset values: state IDLE; operand registers, alu_a/b/key, rsp_result, counter, grant_id all 0; last_grant = 1, so requester 0 wins the first contention; all ready/valid outputs and busy are 0.
- Reset asserted in EXEC or RESP: the in-flight operation is discarded, no rsp pulse is produced, and the FSM is in IDLE on the next cycle.
- Result width: the ALU output is taken as-is and is not re-extended by this block.

Optional Feature:
ALU_ARB_ACC_EN
- Defined:
  - Two RES_W accumulators, acc0 and acc1, both reset to 0.
  - On capture, acc<grant_id> <= alu_out.
  - At transfer, if reqN_use_acc is high, operand B latches accN[DATA_W-1:0] instead of reqN_b.
- Undefined:
  - No accumulators.
  - reqN_use_acc ports exist but are ignored.
  - B always comes from reqN_b.

Decomposition:
- Package alu_arb_pkg holds:
  - state encoding (IDLE/EXEC/RESP);
  - op constants OP_RIPPLE, OP_ADD, OP_ORXOR, OP_ANYONE, OP_ALLONE, OP_SHL, OP_SHR, OP_MUL;
  - default widths.
- One sub-module, rr_arb2: a two-requester round-robin grant from valid[1:0] plus last_grant, pure combinational. The FSM and datapath stay in alu_arbiter.

Test Plan:
- ALU_LAT=0, req0 op=0 A=5 B=3, transfer at T -> alu_key=0 from T+1; rsp0_valid at T+2 only; rsp_result=0x08; rsp1_valid stays 0.
- req1 op=7 A=15 B=15 -> rsp1_valid pulse; rsp_result=0xE1; grant_id=1.
- Both valid held high, op=1, 6 operations -> grant sequence 0,1,0,1,0,1; readies never high together; each rsp pulse lands on the matching requester.
- ALU_ARB_ACC_EN with ALU_LAT=2: req0 op=1 A=5 B=3 -> rsp at T+4, result 0x08. Then req0 op=1 A=1 use_acc=1 -> result 0x09. Then req1 use_acc=1 op=1 A=2 -> 0x02, because acc1 is still 0.
- Reset pulsed one cycle while in EXEC (ALU_LAT=3) -> no rsp pulse; busy=0; rsp_result=0; the next contention grants req0.
- req0_valid dropped in EXEC, reasserted with new operands -> the first result reflects the originally latched operands; the second operation is accepted only once the FSM is back in IDLE.
